// File: rtl/debug_status_if.sv
// Bundle of board-side signals around the debug reset sequencer / status indicator.
// The master drives lock, soft reset and core status; the slave returns reset and LED outputs.
interface debug_status_if #(
    parameter int unsigned N_STATUS = 2,
    parameter int unsigned CNT_W    = 16
);
    logic                      pll_locked;
    logic                      soft_rst_req;
    logic [N_STATUS-1:0]       status_in;
    logic                      core_reset_n;
    logic                      reset_led;
    logic [N_STATUS-1:0]       status_led;
    logic                      heartbeat_led;
    logic [N_STATUS*CNT_W-1:0] event_count;
    logic [1:0]                state_out;

    modport master (
        output pll_locked, soft_rst_req, status_in,
        input  core_reset_n, reset_led, status_led, heartbeat_led, event_count, state_out
    );

    modport slave (
        input  pll_locked, soft_rst_req, status_in,
        output core_reset_n, reset_led, status_led, heartbeat_led, event_count, state_out
    );
endinterface

// File: rtl/debug_status_ctrl.sv
// Core reset sequencer gated on PLL lock, with stretched status LEDs,
// saturating per-channel event counters and a heartbeat LED.
module debug_status_ctrl #(
    parameter int unsigned N_STATUS       = 2,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned RESET_PULSE    = 16,
    parameter int unsigned LOCK_WAIT      = 1024,
    parameter int unsigned STRETCH_CYCLES = 5000000,
    parameter int unsigned HEARTBEAT_DIV  = 25000000
) (
    input  logic           clk,
    input  logic           reset_n,
    debug_status_if.slave  bus
);

    localparam int unsigned CYC_MAX = ((RESET_PULSE > LOCK_WAIT) ? RESET_PULSE : LOCK_WAIT) - 1;
    localparam int unsigned CYC_W   = (CYC_MAX < 1) ? 1 : $clog2(CYC_MAX + 1);
    localparam int unsigned STR_W   = $clog2(STRETCH_CYCLES + 1);
    localparam int unsigned HB_W    = (HEARTBEAT_DIV <= 1) ? 1 : $clog2(HEARTBEAT_DIV);

    localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(RESET_PULSE - 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(LOCK_WAIT - 1);
    localparam logic [STR_W-1:0] STR_LOAD    = STR_W'(STRETCH_CYCLES);
    localparam logic [HB_W-1:0]  HB_LAST     = HB_W'(HEARTBEAT_DIV - 1);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_SETTLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
    logic               lock_meta, lock_s;
    logic               core_rst_n, rst_led;
    logic               clr_ev;
    logic [N_STATUS-1:0] prev, rise, led;
    logic [HB_W-1:0]    hb_cnt;
    logic               hb_led;

    // pll_locked is asynchronous: two-flop synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_HOLD;
            cyc_cnt    <= '0;
            core_rst_n <= 1'b0;
            rst_led    <= 1'b1;
        end else begin
            state      <= state_nxt;
            cyc_cnt    <= cyc_nxt;
            core_rst_n <= (state_nxt == S_RUN);
            rst_led    <= (state_nxt != S_RUN);
        end
    end

    // Next state: soft reset beats lock loss in every state
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        case (state)
            S_HOLD: begin
                if (bus.soft_rst_req) begin
                    cyc_nxt = '0;
                end else if (cyc_cnt == HOLD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_cnt + CYC_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (bus.soft_rst_req) begin
                    state_nxt = S_HOLD;
                    cyc_nxt   = '0;
                end else if (lock_s) begin
                    state_nxt = S_SETTLE;
                    cyc_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (bus.soft_rst_req) begin
                    state_nxt = S_HOLD;
                    cyc_nxt   = '0;
                end else if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cyc_nxt   = '0;
                end else if (cyc_cnt == SETTLE_LAST) begin
                    state_nxt = S_RUN;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_cnt + CYC_W'(1);
                end
            end
            default: begin
                if (bus.soft_rst_req) begin
                    state_nxt = S_HOLD;
                    cyc_nxt   = '0;
                end else if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cyc_nxt   = '0;
                end
            end
        endcase
    end

    assign clr_ev = (state != S_HOLD) && (state_nxt == S_HOLD);
    assign rise   = bus.status_in & ~prev & {N_STATUS{state == S_RUN}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= '0;
        else          prev <= bus.status_in;
    end

    for (genvar g = 0; g < N_STATUS; g++) begin : g_ch
        logic [STR_W-1:0] str_cnt, str_nxt;
        logic [CNT_W-1:0] ev_cnt;

        // Stretch counter is blanked whenever the next cycle is not RUN
        always_comb begin
            str_nxt = '0;
            if (state_nxt == S_RUN) begin
                if (rise[g])             str_nxt = STR_LOAD;
                else if (str_cnt != '0)  str_nxt = str_cnt - STR_W'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                str_cnt <= '0;
                led[g]  <= 1'b0;
                ev_cnt  <= '0;
            end else begin
                str_cnt <= str_nxt;
                led[g]  <= (str_nxt != '0);
                if (clr_ev)
                    ev_cnt <= '0;
                else if (rise[g] && (ev_cnt != '1))
                    ev_cnt <= ev_cnt + CNT_W'(1);
            end
        end

        assign bus.event_count[g*CNT_W +: CNT_W] = ev_cnt;
    end

    // Free-running heartbeat, cleared only by the board reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt <= '0;
            hb_led <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb_led <= ~hb_led;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    assign bus.core_reset_n  = core_rst_n;
    assign bus.reset_led     = rst_led;
    assign bus.status_led    = led;
    assign bus.heartbeat_led = hb_led;
    assign bus.state_out     = state;

endmodule

// File: tb/tb_debug_status_ctrl.sv
// Directed bench for debug_status_ctrl with shortened timing parameters.
module tb_debug_status_ctrl;

    localparam int unsigned N_STATUS = 2;
    localparam int unsigned CNT_W    = 3;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    debug_status_if #(.N_STATUS(N_STATUS), .CNT_W(CNT_W)) bus ();

    debug_status_ctrl #(
        .N_STATUS(N_STATUS), .CNT_W(CNT_W), .RESET_PULSE(4), .LOCK_WAIT(8),
        .STRETCH_CYCLES(3), .HEARTBEAT_DIV(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] ev(input int ch);
        logic [N_STATUS*CNT_W-1:0] v;
        v = bus.event_count;
        return v[ch*CNT_W +: CNT_W];
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        bus.pll_locked = 1'b1;
        bus.soft_rst_req = 1'b0;
        bus.status_in = '0;
        #12;
        total++; if (bus.state_out !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_out); end
        total++; if (bus.core_reset_n !== 1'b0) begin bad++; $display("FAIL reset_core got=%b exp=0", bus.core_reset_n); end
        total++; if (bus.reset_led !== 1'b1) begin bad++; $display("FAIL reset_led got=%b exp=1", bus.reset_led); end
        total++; if (bus.status_led !== 2'b00) begin bad++; $display("FAIL reset_status_led got=%b exp=00", bus.status_led); end
        total++; if (bus.heartbeat_led !== 1'b0) begin bad++; $display("FAIL reset_hb got=%b exp=0", bus.heartbeat_led); end
        total++; if (bus.event_count !== 6'd0) begin bad++; $display("FAIL reset_events got=%h exp=0", bus.event_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_release();
        logic [1:0] exp_st;
        for (int i = 1; i <= 13; i++) begin
            step();
            exp_st = (i <= 3) ? 2'd0 : (i == 4) ? 2'd1 : (i <= 12) ? 2'd2 : 2'd3;
            total++; if (bus.state_out !== exp_st) begin bad++; $display("FAIL release_state edge=%0d got=%0d exp=%0d", i, bus.state_out, exp_st); end
            total++; if (bus.core_reset_n !== (i >= 13)) begin bad++; $display("FAIL release_core edge=%0d got=%b exp=%b", i, bus.core_reset_n, (i >= 13)); end
            total++; if (bus.reset_led !== (i < 13)) begin bad++; $display("FAIL release_led edge=%0d got=%b exp=%b", i, bus.reset_led, (i < 13)); end
        end
    endtask

    task automatic test_stretch();
        total++; if (bus.status_led[0] !== 1'b0) begin bad++; $display("FAIL stretch_idle got=%b exp=0", bus.status_led[0]); end
        bus.status_in[0] = 1'b1;
        step();
        bus.status_in[0] = 1'b0;
        total++; if (ev(0) !== 3'd1) begin bad++; $display("FAIL stretch_count0 got=%0d exp=1", ev(0)); end
        total++; if (ev(1) !== 3'd0) begin bad++; $display("FAIL stretch_count1 got=%0d exp=0", ev(1)); end
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            total++; if (bus.status_led[0] !== (j < 3)) begin bad++; $display("FAIL stretch_single j=%0d got=%b exp=%b", j, bus.status_led[0], (j < 3)); end
        end
        // Retrigger: pulses two cycles apart extend the on-time
        bus.status_in[0] = 1'b1;
        step();
        bus.status_in[0] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j == 2) bus.status_in[0] = 1'b1;
            if (j > 0) step();
            if (j == 2) bus.status_in[0] = 1'b0;
            total++; if (bus.status_led[0] !== (j < 5)) begin bad++; $display("FAIL stretch_retrig j=%0d got=%b exp=%b", j, bus.status_led[0], (j < 5)); end
        end
        total++; if (ev(0) !== 3'd3) begin bad++; $display("FAIL stretch_count_retrig got=%0d exp=3", ev(0)); end
    endtask

    task automatic test_saturate();
        logic [CNT_W-1:0] exp_c;
        bus.status_in[1] = 1'b1;
        for (int j = 0; j < 20; j++) step();
        bus.status_in[1] = 1'b0;
        step();
        total++; if (ev(1) !== 3'd1) begin bad++; $display("FAIL hold_high_count got=%0d exp=1", ev(1)); end
        for (int i = 0; i < 9; i++) begin
            bus.status_in[1] = 1'b1;
            step();
            bus.status_in[1] = 1'b0;
            step();
            exp_c = (i + 2 > 7) ? 3'd7 : 3'(i + 2);
            total++; if (ev(1) !== exp_c) begin bad++; $display("FAIL saturate pulse=%0d got=%0d exp=%0d", i, ev(1), exp_c); end
        end
    endtask

    task automatic test_lock_loss();
        int rise_at;
        bus.pll_locked = 1'b0;
        bus.status_in[0] = 1'b1;
        step();
        bus.status_in[0] = 1'b0;
        total++; if (bus.core_reset_n !== 1'b1 || bus.status_led[0] !== 1'b1) begin bad++; $display("FAIL loss_e1 core=%b led=%b exp=1/1", bus.core_reset_n, bus.status_led[0]); end
        step();
        total++; if (bus.core_reset_n !== 1'b1) begin bad++; $display("FAIL loss_e2 core=%b exp=1", bus.core_reset_n); end
        step();
        total++; if (bus.state_out !== 2'd1) begin bad++; $display("FAIL loss_state got=%0d exp=1", bus.state_out); end
        total++; if (bus.core_reset_n !== 1'b0 || bus.reset_led !== 1'b1) begin bad++; $display("FAIL loss_core core=%b led=%b exp=0/1", bus.core_reset_n, bus.reset_led); end
        total++; if (bus.status_led !== 2'b00) begin bad++; $display("FAIL loss_status_led got=%b exp=00", bus.status_led); end
        total++; if (ev(0) !== 3'd4 || ev(1) !== 3'd7) begin bad++; $display("FAIL loss_counts got=%0d/%0d exp=4/7", ev(0), ev(1)); end
        // Lock returns, then drops again partway through SETTLE
        bus.pll_locked = 1'b1;
        repeat (3) step();
        total++; if (bus.state_out !== 2'd2) begin bad++; $display("FAIL settle_entry got=%0d exp=2", bus.state_out); end
        repeat (3) step();
        bus.pll_locked = 1'b0;
        repeat (2) step();
        total++; if (bus.state_out !== 2'd2) begin bad++; $display("FAIL settle_drop_e2 got=%0d exp=2", bus.state_out); end
        step();
        total++; if (bus.state_out !== 2'd1 || bus.core_reset_n !== 1'b0) begin bad++; $display("FAIL settle_drop state=%0d core=%b exp=1/0", bus.state_out, bus.core_reset_n); end
        // Release latency from first sampled lock edge
        bus.pll_locked = 1'b1;
        rise_at = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (bus.core_reset_n === 1'b1) begin rise_at = n; break; end
        end
        total++; if (rise_at != 11) begin bad++; $display("FAIL release_latency got=%0d exp=11", rise_at); end
        total++; if (ev(0) !== 3'd4 || ev(1) !== 3'd7) begin bad++; $display("FAIL preserve_counts got=%0d/%0d exp=4/7", ev(0), ev(1)); end
    endtask

    task automatic test_soft_reset();
        bus.soft_rst_req = 1'b1;
        bus.pll_locked = 1'b0;
        step();
        bus.soft_rst_req = 1'b0;
        total++; if (bus.state_out !== 2'd0 || bus.core_reset_n !== 1'b0) begin bad++; $display("FAIL soft_state state=%0d core=%b exp=0/0", bus.state_out, bus.core_reset_n); end
        total++; if (bus.event_count !== 6'd0) begin bad++; $display("FAIL soft_clear got=%h exp=0", bus.event_count); end
        repeat (2) step();
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) step();
            total++; if (bus.state_out !== ((j < 4) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL soft_rehold j=%0d got=%0d exp=%0d", j, bus.state_out, (j < 4) ? 0 : 1); end
        end
    endtask

    task automatic test_async_reset();
        bit reached;
        bus.pll_locked = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            step();
            if (bus.state_out === 2'd3) reached = 1'b1;
        end
        total++; if (!reached) begin bad++; $display("FAIL reach_run state=%0d exp=3", bus.state_out); end
        bus.status_in = 2'b11;
        step();
        bus.status_in = 2'b00;
        total++; if (bus.status_led !== 2'b11) begin bad++; $display("FAIL pre_reset_leds got=%b exp=11", bus.status_led); end
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (bus.state_out !== 2'd0 || bus.core_reset_n !== 1'b0 || bus.reset_led !== 1'b1) begin bad++; $display("FAIL async_core state=%0d core=%b led=%b exp=0/0/1", bus.state_out, bus.core_reset_n, bus.reset_led); end
        total++; if (bus.status_led !== 2'b00 || bus.heartbeat_led !== 1'b0) begin bad++; $display("FAIL async_leds status=%b hb=%b exp=00/0", bus.status_led, bus.heartbeat_led); end
        total++; if (bus.event_count !== 6'd0) begin bad++; $display("FAIL async_events got=%h exp=0", bus.event_count); end
    endtask

    task automatic test_heartbeat();
        logic exp_hb;
        reset_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            exp_hb = ((n / 5) % 2) == 1;
            total++; if (bus.heartbeat_led !== exp_hb) begin bad++; $display("FAIL heartbeat edge=%0d got=%b exp=%b", n, bus.heartbeat_led, exp_hb); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_release();
        test_stretch();
        test_saturate();
        test_lock_loss();
        test_soft_reset();
        test_async_reset();
        test_heartbeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
